ether_rx_frame_checker: RTL and testbench
=========================================

// Module: ether_rx_frame_checker
// PURPOSE
// - Sits on the core_clk side, directly downstream of ether_if's m_rx_* dibit stream (last/data/valid, 2-bit).
// - Strips preamble/SFD and forwards the frame body (DA..FCS) with a first-flag.
// - Checks CRC32, length and alignment; emits one status word per frame and keeps saturating statistics counters.
// - Intended consumers: the bridge/forwarding logic and the SPU observation taps.
// PARAMETERS
// - DATA_BITS     2   stream width in bits; only 2 is supported; any other value is an elaboration error
// - MIN_PREAMBLE  8   minimum count of 2'b01 dibits required before the SFD dibit
// - MIN_LEN       64  frame length in bytes (DA..FCS) below which the runt flag is set
// - LEN_BITS      16  width of the length field; the length saturates at all-ones
// - CNT_BITS      32  width of each statistics counter; counters saturate at all-ones
// PORTS
// - reset_n           in   1          asynchronous, active-low reset
// - clk               in   1          core clock; single clock domain
// - s_last            in   1          input last beat of frame
// - s_data            in   DATA_BITS  input dibit; LSB-first within each byte
// - s_valid           in   1          input beat qualifier; gaps inside a frame are allowed
// - m_first           out  1          first body dibit (first dibit of DA)
// - m_last            out  1          last body dibit (last dibit of FCS)
// - m_data            out  DATA_BITS  body dibit
// - m_valid           out  1          body beat valid
// - m_status_valid    out  1          one-cycle pulse per completed frame
// - m_status_fcs_ok   out  1          CRC residue matched
// - m_status_runt     out  1          length < MIN_LEN
// - m_status_align    out  1          body dibit count not a multiple of 4
// - m_status_framing  out  1          preamble/SFD violation
// - m_status_length   out  LEN_BITS   body length in whole bytes
// - cnt_good          out  CNT_BITS   frames with fcs_ok and no other flag set
// - cnt_fcs_err       out  CNT_BITS   frames with fcs_ok=0 and framing=0
// - cnt_framing_err   out  CNT_BITS   frames with framing=1
// BEHAVIOUR
// - Clock/reset: single clock clk; reset_n is asynchronous and active-low. While reset_n=0, every output is 0 and the FSM is in IDLE.
// - Frame start: the first s_valid beat after reset or after an s_last beat.
// - FSM states:
//   - IDLE: on the first beat with s_data=01, go to PRE with pcnt=1. On any other first beat, go to DROP.
//   - PRE:
//     - data 01: pcnt++, saturating at 255.
//     - data 11 with pcnt>=MIN_PREAMBLE: go to BODY, CRC=32'hFFFF_FFFF, len=0.
//     - data 11 with pcnt<MIN_PREAMBLE, or data 00/10: go to DROP.
//   - BODY: each beat updates CRC with the reflected polynomial 0xEDB88320, 2 bits per beat, bit0 first.
//   - DROP: consumes beats until s_last; nothing is forwarded.
// - End-of-frame transitions:
//   - s_last in BODY: go to IDLE; status is emitted.
//   - s_last in PRE or DROP: go to IDLE; status is emitted with framing=1, fcs_ok=0, length=0.
//   - s_last on the IDLE beat itself: framing=1.
// - Body forwarding:
//   - Latency is 1 cycle, registered: m_* equals the previous cycle's BODY beat.
//   - The SFD and preamble dibits are never forwarded.
//   - m_first is set on the first BODY beat; m_last equals s_last.
//   - m_valid=0 on gap cycles, and m_data is held at 0 on those cycles.
// - Status, registered in the same cycle as m_last:
//   - fcs_ok: the CRC register after the FCS dibit equals 32'hDEBB20E3.
//   - length: BODY dibit count >> 2.
//   - align: BODY dibit count[1:0] != 0.
//   - runt: length < MIN_LEN.
// - Counters:
//   - All counters update one cycle after m_status_valid and saturate at all-ones, with no wrap.
//   - At most one counter increments per frame.
//   - Precedence: framing > fcs_err > good. A runt or misaligned frame with a bad FCS counts as fcs_err; a runt with a good FCS increments no counter.
// - Length: the internal dibit counter saturates at LEN_BITS+2 bits of all-ones; the length field then reads all-ones.
// - s_last with s_valid=0 is ignored.
// - Reset mid-frame: all state and counters are cleared. The first beat after release starts a new frame; a partial frame therefore normally ends as a framing error.
// - No backpressure: the block consumes one beat every valid cycle.
// STRUCTURE
// - ether_pkg (shared package) holds:
//   - PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11
//   - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFF_FFFF, CRC_RESIDUE=32'hDEBB20E3
//   - state_t enum {IDLE,PRE,BODY,DROP}
//   - frame_status_t packed struct {fcs_ok,runt,align,framing,length}
// - Sub-module ether_crc32_d2: purely combinational; inputs crc_in[31:0] and dibit; output crc_out. It is reused by the future TX FCS inserter.
// TESTING
// - 31x01 + 11 + 64-byte frame with correct FCS (from the bench model):
//   - m_first on the first DA dibit; 256 m_valid beats.
//   - Status: fcs_ok=1, length=64, other flags 0; cnt_good=1.
// - Same frame with bit 3 of byte 20 flipped: fcs_ok=0, length=64, cnt_fcs_err=1, cnt_good unchanged.
// - 4x01 + 11 + 64-byte frame: framing=1, no m_valid beats, cnt_framing_err=1.
// - 40-byte frame with good FCS, then a 64-byte frame with 1 extra dibit:
//   - First frame: runt=1, length=40.
//   - Second frame: align=1, length=64, fcs_ok=0.
// - Valid gaps: random 0-3 cycle gaps in the first test's frame.
//   - Same status as the first test.
//   - m_data stream identical to the gap-free run.
// - Reset pulse at body beat 100, then 2 good frames: all outputs 0 during reset; first post-reset frame reports framing=1.
// - Saturation: preload CNT_BITS=4 and run 17 good frames: cnt_good holds at 15.

Source files
------------

// File: rtl/ether_pkg.sv
// Shared definitions for the Ethernet RX path: dibit codes, CRC32 constants,
// receive FSM state encoding and the per-frame status word.
`timescale 1ns/1ps
package ether_pkg;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;

    localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

    // Widest length field the status word can carry.
    localparam int          STATUS_LEN_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic                      fcs_ok;
        logic                      runt;
        logic                      align;
        logic                      framing;
        logic [STATUS_LEN_MAX-1:0] length;
    } frame_status_t;

endpackage

// File: rtl/ether_crc32_d2.sv
// Combinational CRC32 step over one dibit, reflected polynomial, bit0 first.
// Shared by the RX checker and the TX FCS inserter.
// Ports:
//   crc_in  - CRC register before this dibit
//   dibit   - two data bits, bit0 is processed first
//   crc_out - CRC register after this dibit
`timescale 1ns/1ps
module ether_crc32_d2
    import ether_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    logic [31:0] crc_mid;

    assign crc_mid = {1'b0, crc_in[31:1]}  ^ ((crc_in[0]  ^ dibit[0]) ? CRC_POLY : 32'h0);
    assign crc_out = {1'b0, crc_mid[31:1]} ^ ((crc_mid[0] ^ dibit[1]) ? CRC_POLY : 32'h0);

endmodule

// File: rtl/ether_rx_frame_checker.sv
// Ethernet RX frame checker on the dibit stream from ether_if. Strips the
// preamble/SFD, forwards DA..FCS with a first flag one cycle later, and emits
// one status word per frame (FCS, runt, alignment, framing, length) plus
// saturating good / FCS-error / framing-error counters.
// Ports:
//   reset_n, clk                  - async active-low reset, core clock
//   s_last, s_data, s_valid       - input dibit stream
//   m_first, m_last, m_data,
//   m_valid                       - forwarded frame body
//   m_status_*                    - per-frame status, valid for one cycle
//   cnt_good, cnt_fcs_err,
//   cnt_framing_err               - saturating statistics counters
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// PRE   | counting preamble dibits, waiting for the SFD
// BODY  | forwarding DA..FCS and running the CRC
// DROP  | bad preamble/SFD, discarding beats until s_last
`timescale 1ns/1ps
module ether_rx_frame_checker
    import ether_pkg::*;
#(
    parameter int DATA_BITS    = 2,
    parameter int MIN_PREAMBLE = 8,
    parameter int MIN_LEN      = 64,
    parameter int LEN_BITS     = 16,
    parameter int CNT_BITS     = 32
) (
    input  logic                 reset_n,
    input  logic                 clk,
    input  logic                 s_last,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 m_first,
    output logic                 m_last,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_status_valid,
    output logic                 m_status_fcs_ok,
    output logic                 m_status_runt,
    output logic                 m_status_align,
    output logic                 m_status_framing,
    output logic [LEN_BITS-1:0]  m_status_length,
    output logic [CNT_BITS-1:0]  cnt_good,
    output logic [CNT_BITS-1:0]  cnt_fcs_err,
    output logic [CNT_BITS-1:0]  cnt_framing_err
);

    generate
        if (DATA_BITS != 2) begin : g_bad_data_bits
            $error("ether_rx_frame_checker: only DATA_BITS=2 is supported");
        end
        if (LEN_BITS > STATUS_LEN_MAX) begin : g_bad_len_bits
            $error("ether_rx_frame_checker: LEN_BITS exceeds status word length field");
        end
    endgenerate

    localparam int                  DCNT_W      = LEN_BITS + 2;
    localparam logic [7:0]          MIN_PRE_CNT = 8'(MIN_PREAMBLE);
    localparam logic [LEN_BITS-1:0] MIN_LEN_L   = LEN_BITS'(MIN_LEN);

    state_t                state_q, state_d;
    logic [7:0]            pcnt_q, pcnt_d;
    logic [31:0]           crc_q, crc_d;
    logic [31:0]           crc_next;
    logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
    logic [LEN_BITS-1:0]   len_nxt;
    logic                  first_pend_q, first_pend_d;

    logic                  m_first_q, m_first_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_BITS-1:0]  m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  stat_valid_q, stat_valid_d;
    frame_status_t         status_q, status_d;

    logic [CNT_BITS-1:0]   cnt_good_q, cnt_good_d;
    logic [CNT_BITS-1:0]   cnt_fcs_q, cnt_fcs_d;
    logic [CNT_BITS-1:0]   cnt_framing_q, cnt_framing_d;

    ether_crc32_d2 u_crc (
        .crc_in  (crc_q),
        .dibit   (s_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        crc_d        = crc_q;
        dcnt_d       = dcnt_q;
        first_pend_d = first_pend_q;
        m_first_d    = 1'b0;
        m_last_d     = 1'b0;
        m_data_d     = '0;
        m_valid_d    = 1'b0;
        stat_valid_d = 1'b0;
        status_d     = '0;
        len_nxt      = '0;

        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (s_data == PREAMBLE_DIBIT) begin
                        state_d = PRE;
                        pcnt_d  = 8'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
                PRE: begin
                    if (s_data == PREAMBLE_DIBIT) begin
                        if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
                    end else if (s_data == SFD_DIBIT && pcnt_q >= MIN_PRE_CNT) begin
                        state_d      = BODY;
                        crc_d        = CRC_INIT;
                        dcnt_d       = '0;
                        first_pend_d = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
                BODY: begin
                    m_valid_d    = 1'b1;
                    m_first_d    = first_pend_q;
                    m_last_d     = s_last;
                    m_data_d     = s_data;
                    first_pend_d = 1'b0;
                    crc_d        = crc_next;
                    if (dcnt_q != '1) dcnt_d = dcnt_q + DCNT_W'(1);
                end
                default: ;
            endcase

            // End of frame: the status uses the count and CRC including this beat.
            if (s_last) begin
                state_d      = IDLE;
                stat_valid_d = 1'b1;
                if (state_q == BODY) begin
                    len_nxt          = dcnt_d[DCNT_W-1:2];
                    status_d.fcs_ok  = (crc_next == CRC_RESIDUE);
                    status_d.length  = STATUS_LEN_MAX'(len_nxt);
                    status_d.align   = (dcnt_d[1:0] != 2'b00);
                    status_d.runt    = (len_nxt < MIN_LEN_L);
                end else begin
                    status_d.framing = 1'b1;
                end
            end
        end
    end

    // Counters follow the registered status, so they move one cycle after it.
    always_comb begin
        cnt_good_d    = cnt_good_q;
        cnt_fcs_d     = cnt_fcs_q;
        cnt_framing_d = cnt_framing_q;
        if (stat_valid_q) begin
            if (status_q.framing) begin
                if (cnt_framing_q != '1) cnt_framing_d = cnt_framing_q + CNT_BITS'(1);
            end else if (!status_q.fcs_ok) begin
                if (cnt_fcs_q != '1) cnt_fcs_d = cnt_fcs_q + CNT_BITS'(1);
            end else if (!status_q.runt && !status_q.align) begin
                if (cnt_good_q != '1) cnt_good_d = cnt_good_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pcnt_q        <= '0;
            crc_q         <= '0;
            dcnt_q        <= '0;
            first_pend_q  <= 1'b0;
            m_first_q     <= 1'b0;
            m_last_q      <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            stat_valid_q  <= 1'b0;
            status_q      <= '0;
            cnt_good_q    <= '0;
            cnt_fcs_q     <= '0;
            cnt_framing_q <= '0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            crc_q         <= crc_d;
            dcnt_q        <= dcnt_d;
            first_pend_q  <= first_pend_d;
            m_first_q     <= m_first_d;
            m_last_q      <= m_last_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            stat_valid_q  <= stat_valid_d;
            status_q      <= status_d;
            cnt_good_q    <= cnt_good_d;
            cnt_fcs_q     <= cnt_fcs_d;
            cnt_framing_q <= cnt_framing_d;
        end
    end

    assign m_first          = m_first_q;
    assign m_last           = m_last_q;
    assign m_data           = m_data_q;
    assign m_valid          = m_valid_q;
    assign m_status_valid   = stat_valid_q;
    assign m_status_fcs_ok  = status_q.fcs_ok;
    assign m_status_runt    = status_q.runt;
    assign m_status_align   = status_q.align;
    assign m_status_framing = status_q.framing;
    assign m_status_length  = status_q.length[LEN_BITS-1:0];
    assign cnt_good         = cnt_good_q;
    assign cnt_fcs_err      = cnt_fcs_q;
    assign cnt_framing_err  = cnt_framing_q;

endmodule

// File: tb/tb_ether_rx_frame_checker.sv
`timescale 1ns/1ps
module tb_ether_rx_frame_checker;

    localparam int MIN_PRE = 8;
    localparam int MIN_LEN = 64;

    typedef byte unsigned bytes_t[$];
    typedef bit [1:0]     dibits_t[$];
    typedef struct {
        bit fcs_ok;
        bit runt;
        bit align;
        bit framing;
        int length;
    } exp_stat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_last = 1'b0;
    logic [1:0]  s_data = 2'b00;
    logic        s_valid = 1'b0;

    logic        m_first, m_last, m_valid, m_status_valid;
    logic [1:0]  m_data;
    logic        m_status_fcs_ok, m_status_runt, m_status_align, m_status_framing;
    logic [15:0] m_status_length;
    logic [31:0] cnt_good, cnt_fcs_err, cnt_framing_err;

    logic        m_first_s, m_last_s, m_valid_s, m_status_valid_s;
    logic [1:0]  m_data_s;
    logic        m_status_fcs_ok_s, m_status_runt_s, m_status_align_s, m_status_framing_s;
    logic [15:0] m_status_length_s;
    logic [3:0]  cnt_good_s, cnt_fcs_err_s, cnt_framing_err_s;

    always #5 clk = ~clk;

    ether_rx_frame_checker dut (
        .reset_n(reset_n), .clk(clk), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
        .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid),
        .m_status_valid(m_status_valid), .m_status_fcs_ok(m_status_fcs_ok),
        .m_status_runt(m_status_runt), .m_status_align(m_status_align),
        .m_status_framing(m_status_framing), .m_status_length(m_status_length),
        .cnt_good(cnt_good), .cnt_fcs_err(cnt_fcs_err), .cnt_framing_err(cnt_framing_err)
    );

    ether_rx_frame_checker #(.CNT_BITS(4)) dut_sat (
        .reset_n(reset_n), .clk(clk), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
        .m_first(m_first_s), .m_last(m_last_s), .m_data(m_data_s), .m_valid(m_valid_s),
        .m_status_valid(m_status_valid_s), .m_status_fcs_ok(m_status_fcs_ok_s),
        .m_status_runt(m_status_runt_s), .m_status_align(m_status_align_s),
        .m_status_framing(m_status_framing_s), .m_status_length(m_status_length_s),
        .cnt_good(cnt_good_s), .cnt_fcs_err(cnt_fcs_err_s), .cnt_framing_err(cnt_framing_err_s)
    );

    exp_stat_t   stat_q[$];
    logic [3:0]  beat_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    longint      exp_good = 0, exp_fcs = 0, exp_framing = 0;
    int          sat_good = 0, sat_fcs = 0, sat_framing = 0;
    bit          cnt_check_pending = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference CRC-32 (IEEE 802.3) over whole bytes; returns the FCS value.
    function automatic bit [31:0] crc32(input bytes_t b, input int n);
        bit [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= 32'(b[i]);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bytes_t make_bytes(input int n);
        bytes_t b;
        bit [31:0] f;
        for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
        f = crc32(b, n - 4);
        for (int k = 0; k < 4; k++) b.push_back(f[8*k +: 8]);
        return b;
    endfunction

    function automatic dibits_t to_dibits(input int npre, input bit [1:0] sfd, input bytes_t b,
                                          input int nextra, input bit [1:0] xd);
        dibits_t d;
        bit [7:0] v;
        repeat (npre) d.push_back(2'b01);
        d.push_back(sfd);
        foreach (b[j]) begin
            v = b[j];
            for (int k = 0; k < 4; k++) d.push_back(v[2*k +: 2]);
        end
        repeat (nextra) d.push_back(xd);
        return d;
    endfunction

    // Model: parse a frame's dibits and queue the expected body beats and status.
    function automatic void expect_frame(input dibits_t d);
        exp_stat_t e;
        bytes_t    bb;
        int        n = 0;
        int        bs, blen, nb;
        bit [31:0] fcs;
        e = '{fcs_ok: 0, runt: 0, align: 0, framing: 1, length: 0};
        while (n < d.size() && d[n] == 2'b01) n++;
        if (n >= MIN_PRE && n < d.size() - 1 && d[n] == 2'b11) begin
            bs   = n + 1;
            blen = d.size() - bs;
            for (int i = 0; i < blen; i++)
                beat_q.push_back({i == 0, i == blen - 1, d[bs + i]});
            e.framing = 0;
            e.length  = blen / 4;
            e.align   = (blen % 4) != 0;
            e.runt    = e.length < MIN_LEN;
            nb        = e.length;
            if (!e.align && nb >= 4) begin
                for (int j = 0; j < nb; j++)
                    bb.push_back({d[bs+4*j+3], d[bs+4*j+2], d[bs+4*j+1], d[bs+4*j]});
                fcs = {bb[nb-1], bb[nb-2], bb[nb-3], bb[nb-4]};
                e.fcs_ok = (crc32(bb, nb - 4) == fcs);
            end
        end
        stat_q.push_back(e);
    endfunction

    function automatic void count_frame(input exp_stat_t e);
        if (e.framing) begin
            if (exp_framing < 64'hFFFF_FFFF) exp_framing++;
            if (sat_framing < 15) sat_framing++;
        end else if (!e.fcs_ok) begin
            if (exp_fcs < 64'hFFFF_FFFF) exp_fcs++;
            if (sat_fcs < 15) sat_fcs++;
        end else if (!e.runt && !e.align) begin
            if (exp_good < 64'hFFFF_FFFF) exp_good++;
            if (sat_good < 15) sat_good++;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stream"}, {m_first, m_last, m_data, m_valid}, 0);
        check({tag, "_status"}, {m_status_valid, m_status_fcs_ok, m_status_runt,
                                 m_status_align, m_status_framing, m_status_length}, 0);
        check({tag, "_cnt_good"}, cnt_good, 0);
        check({tag, "_cnt_fcs"}, cnt_fcs_err, 0);
        check({tag, "_cnt_framing"}, cnt_framing_err, 0);
        check({tag, "_sat_cnts"}, {cnt_good_s, cnt_fcs_err_s, cnt_framing_err_s}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 s_valid = 0; s_last = 0; s_data = 0;
        @(posedge clk);
        #2 reset_n = 0;
        stat_q.delete();
        beat_q.delete();
        cnt_check_pending = 0;
        exp_good = 0; exp_fcs = 0; exp_framing = 0;
        sat_good = 0; sat_fcs = 0; sat_framing = 0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("in_reset");
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic drive(input dibits_t d, input int max_gap, input int reset_at);
        for (int i = 0; i < d.size(); i++) begin
            if (i == reset_at) begin
                do_reset();
                expect_frame(d[i:$]);
            end
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap)) begin
                    @(posedge clk);
                    #1 s_valid = 0; s_last = 1'($urandom); s_data = 2'($urandom);
                end
            end
            @(posedge clk);
            #1 s_valid = 1; s_data = d[i]; s_last = (i == d.size() - 1);
        end
        @(posedge clk);
        #1 s_valid = 0; s_last = 0; s_data = 0;
    endtask

    task automatic send(input dibits_t d, input int max_gap);
        expect_frame(d);
        drive(d, max_gap, -1);
        repeat (4) @(posedge clk);
        if (stat_q.size() != 0 || beat_q.size() != 0) begin
            fail_now("frame_output_missing");
            stat_q.delete();
            beat_q.delete();
        end
    endtask

    // Monitor: compares every presented output against the queued expectations.
    always @(negedge clk) begin
        exp_stat_t e;
        logic [3:0] b;
        if (cnt_check_pending) begin
            cnt_check_pending = 0;
            check("cnt_good", cnt_good, exp_good);
            check("cnt_fcs_err", cnt_fcs_err, exp_fcs);
            check("cnt_framing_err", cnt_framing_err, exp_framing);
            check("sat_cnt_good", cnt_good_s, sat_good);
            check("sat_cnt_fcs_err", cnt_fcs_err_s, sat_fcs);
            check("sat_cnt_framing_err", cnt_framing_err_s, sat_framing);
        end
        if (reset_n) begin
            if (m_valid) begin
                if (beat_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    b = beat_q.pop_front();
                    check("beat_first_last_data", {m_first, m_last, m_data}, b);
                end
            end else begin
                check("gap_zero", {m_first, m_last, m_data}, 0);
            end
            if (m_status_valid) begin
                if (stat_q.size() == 0) fail_now("unexpected_status");
                else begin
                    e = stat_q.pop_front();
                    check("st_framing", m_status_framing, e.framing);
                    check("st_fcs_ok", m_status_fcs_ok, e.fcs_ok);
                    check("st_length", m_status_length, e.length);
                    if (!e.framing) begin
                        check("st_runt", m_status_runt, e.runt);
                        check("st_align", m_status_align, e.align);
                    end
                    count_frame(e);
                    cnt_check_pending = 1;
                end
            end
        end
    end

    initial begin
        bytes_t  b1, b2, b3;
        dibits_t d;
        int      k;

        repeat (3) @(posedge clk);
        #1 check_all_zero("por");
        @(negedge clk);
        reset_n = 1;
        repeat (2) @(posedge clk);

        b1 = make_bytes(64);
        send(to_dibits(31, 2'b11, b1, 0, 2'b00), 0);

        b2 = b1;
        b2[20] = b2[20] ^ 8'h08;
        send(to_dibits(31, 2'b11, b2, 0, 2'b00), 0);

        send(to_dibits(4, 2'b11, b1, 0, 2'b00), 0);

        b3 = make_bytes(40);
        send(to_dibits(8, 2'b11, b3, 0, 2'b00), 0);
        send(to_dibits(8, 2'b11, make_bytes(64), 1, 2'b00), 0);

        send(to_dibits(31, 2'b11, b1, 0, 2'b00), 3);
        check("cnt_good_after_directed", cnt_good, 2);

        d = to_dibits(31, 2'b11, b1, 0, 2'b00);
        expect_frame(d);
        drive(d, 0, 32 + 100);
        repeat (4) @(posedge clk);
        if (stat_q.size() != 0 || beat_q.size() != 0) begin
            fail_now("reset_frame_output_missing");
            stat_q.delete();
            beat_q.delete();
        end
        check("post_reset_framing_cnt", cnt_framing_err, 1);

        for (int i = 0; i < 17; i++)
            send(to_dibits($urandom_range(8, 20), 2'b11, make_bytes($urandom_range(64, 96)), 0, 2'b00),
                 (i < 2) ? 0 : 2);
        check("good_after_17", cnt_good, 17);
        check("sat_good_holds_15", cnt_good_s, 15);

        for (int i = 0; i < 12; i++) begin
            b2 = make_bytes($urandom_range(20, 80));
            if ($urandom_range(2) == 0) begin
                k = $urandom_range(b2.size() - 1);
                b2[k] = b2[k] ^ 8'(1 << $urandom_range(7));
            end
            send(to_dibits($urandom_range(0, 12), ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11,
                           b2, $urandom_range(0, 3), 2'($urandom)), $urandom_range(0, 2));
        end

        k = 0;
        while (k < 100 && (stat_q.size() != 0 || beat_q.size() != 0 || cnt_check_pending)) begin
            @(posedge clk);
            k++;
        end
        if (stat_q.size() != 0 || beat_q.size() != 0) fail_now("final_drain_timeout");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
